// File: rtl/bullet_base_collision_array.sv
// -----------------------------------------------------------------------------
// bullet_base_collision_array
//
// Purpose:
//   Once per video frame, checks every player bullet against the hit window of
//   every live enemy base in parallel. It then produces per-base hit pulses and
//   per-bullet consume pulses. It also keeps a damage counter and an
//   alive/destroyed state for each base. Optionally, it schedules base respawns.
//
// Configuration macro:
//   BULLET_COLLISION_RESPAWN_EN
//     Defined:   a destroyed base comes back to life after RESPAWN_FRAMES
//                frames.
//     Undefined: destruction is permanent until reset, no respawn timers are
//                built, and all_destroyed latches once every base is dead.
//
// Ports:
//   frame_clk        in   single clock, one rising edge per video frame
//   Reset_n          in   asynchronous, active-low reset
//   bullet_valid     in   [NUM_BULLETS]     bullet i is in flight
//   bullet_x/y       in   [10*NUM_BULLETS]  packed bullet positions
//   base_tl_x/y      in   [10*NUM_BASES]    packed base top-left corners
//   base_hit         out  [NUM_BASES]       one-frame pulse, base took damage
//   bullet_consumed  out  [NUM_BULLETS]     one-frame pulse, retire bullet
//   enemy_hit        out                    OR of base_hit
//   base_destroyed   out  [NUM_BASES]       one-frame pulse, base went DEAD
//   base_alive       out  [NUM_BASES]       level, base is ALIVE
//   destroyed_count  out  [clog2(NUM_BASES+1)] number of DEAD bases
//   all_destroyed    out                    every base is DEAD
// -----------------------------------------------------------------------------
module bullet_base_collision_array #(
  parameter int NUM_BULLETS     = 2,
  parameter int NUM_BASES       = 4,
  parameter int HIT_RADIUS      = 5,
  parameter int BASE_HALF_X     = 32,
  parameter int BASE_HALF_Y     = 36,
  parameter int HITS_TO_DESTROY = 3,
  parameter int RESPAWN_FRAMES  = 120
) (
  input  logic                               frame_clk,
  input  logic                               Reset_n,
  input  logic [NUM_BULLETS-1:0]             bullet_valid,
  input  logic [10*NUM_BULLETS-1:0]          bullet_x,
  input  logic [10*NUM_BULLETS-1:0]          bullet_y,
  input  logic [10*NUM_BASES-1:0]            base_tl_x,
  input  logic [10*NUM_BASES-1:0]            base_tl_y,
  output logic [NUM_BASES-1:0]               base_hit,
  output logic [NUM_BULLETS-1:0]             bullet_consumed,
  output logic                               enemy_hit,
  output logic [NUM_BASES-1:0]               base_destroyed,
  output logic [NUM_BASES-1:0]               base_alive,
  output logic [$clog2(NUM_BASES+1)-1:0]     destroyed_count,
  output logic                               all_destroyed
);

  localparam int CNT_W = $clog2(NUM_BASES + 1);

  // All window arithmetic is done at 11 bits, so centre + radius cannot wrap.
  localparam logic [10:0] RADIUS = 11'(HIT_RADIUS);
  localparam logic [10:0] HALF_X = 11'(BASE_HALF_X);
  localparam logic [10:0] HALF_Y = 11'(BASE_HALF_Y);
  localparam logic [4:0]  HITS_LIMIT = 5'(HITS_TO_DESTROY);

  typedef enum logic {
    ALIVE = 1'b0,
    DEAD  = 1'b1
  } base_state_t;

  base_state_t state_q [NUM_BASES];
  base_state_t state_d [NUM_BASES];
  logic [3:0]  dmg_q   [NUM_BASES];
  logic [3:0]  dmg_d   [NUM_BASES];

`ifdef BULLET_COLLISION_RESPAWN_EN
  logic [9:0]  respawn_cnt_q [NUM_BASES];
  logic [9:0]  respawn_cnt_d [NUM_BASES];
`endif

  logic [10:0] cx [NUM_BASES];
  logic [10:0] cy [NUM_BASES];
  logic [10:0] bx [NUM_BULLETS];
  logic [10:0] by [NUM_BULLETS];

  logic [NUM_BULLETS-1:0][NUM_BASES-1:0] overlap;
  logic [NUM_BULLETS-1:0][NUM_BASES-1:0] credit;
  logic [NUM_BULLETS-1:0]                consume_d;
  logic [NUM_BASES-1:0]                  damage;
  logic [NUM_BASES-1:0]                  destroy_d;
  logic [NUM_BASES-1:0]                  respawn_d;
  logic [CNT_W-1:0]                      count_d;
  logic                                  all_d;

  // Unpack the base corners into 11-bit centres and widen the bullet
  // positions so that every later comparison is done at one common width.
  always_comb begin
    for (int j = 0; j < NUM_BASES; j++) begin
      cx[j] = {1'b0, base_tl_x[10*j +: 10]} + HALF_X;
      cy[j] = {1'b0, base_tl_y[10*j +: 10]} + HALF_Y;
    end
    for (int i = 0; i < NUM_BULLETS; i++) begin
      bx[i] = {1'b0, bullet_x[10*i +: 10]};
      by[i] = {1'b0, bullet_y[10*i +: 10]};
    end
  end

  // Inclusive square window test. The radius is added to the bullet side
  // rather than subtracted from the centre. This keeps the test correct near
  // the screen origin, where centre - radius would underflow.
  always_comb begin
    overlap = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      for (int j = 0; j < NUM_BASES; j++) begin
        overlap[i][j] = bullet_valid[i]
                      && (state_q[j] == ALIVE)
                      && (bx[i] + RADIUS >= cx[j]) && (bx[i] <= cx[j] + RADIUS)
                      && (by[i] + RADIUS >= cy[j]) && (by[i] <= cy[j] + RADIUS);
      end
    end
  end

  // Credit each bullet to the lowest-index base it overlaps. Any overlap at
  // all consumes the bullet, even though only one base receives the credit.
  always_comb begin
    logic taken;
    taken     = 1'b0;
    credit    = '0;
    consume_d = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      taken = 1'b0;
      for (int j = 0; j < NUM_BASES; j++) begin
        if (overlap[i][j] && !taken) begin
          credit[i][j] = 1'b1;
          taken        = 1'b1;
        end
      end
      consume_d[i] = |overlap[i];
    end
  end

  // A base is damaged at most once per frame, however many bullets landed.
  always_comb begin
    damage = '0;
    for (int j = 0; j < NUM_BASES; j++) begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        damage[j] = damage[j] | credit[i][j];
      end
    end
  end

  // Per-base next-state logic. An ALIVE base counts damaging frames until it
  // reaches the destroy threshold. A DEAD base either waits out its respawn
  // timer or stays dead for good, depending on the build.
  always_comb begin
    destroy_d = '0;
    respawn_d = '0;
    for (int j = 0; j < NUM_BASES; j++) begin
      state_d[j] = state_q[j];
      dmg_d[j]   = dmg_q[j];
`ifdef BULLET_COLLISION_RESPAWN_EN
      respawn_cnt_d[j] = respawn_cnt_q[j];
`endif
      case (state_q[j])
        ALIVE: begin
          if (damage[j]) begin
            if ({1'b0, dmg_q[j]} + 5'd1 == HITS_LIMIT) begin
              state_d[j]   = DEAD;
              dmg_d[j]     = 4'd0;
              destroy_d[j] = 1'b1;
`ifdef BULLET_COLLISION_RESPAWN_EN
              respawn_cnt_d[j] = 10'(RESPAWN_FRAMES - 1);
`endif
            end else begin
              dmg_d[j] = dmg_q[j] + 4'd1;
            end
          end
        end
        DEAD: begin
`ifdef BULLET_COLLISION_RESPAWN_EN
          // The frame on which the timer reads zero is the final dead frame.
          if (respawn_cnt_q[j] == 10'd0) begin
            state_d[j]   = ALIVE;
            dmg_d[j]     = 4'd0;
            respawn_d[j] = 1'b1;
          end else begin
            respawn_cnt_d[j] = respawn_cnt_q[j] - 10'd1;
          end
`endif
        end
        default: begin
          state_d[j] = ALIVE;
        end
      endcase
    end
  end

  // Up/down dead-base counter. A destroy and a respawn on different bases in
  // the same frame cancel out, so the count stays in step with base_alive.
  always_comb begin
    count_d = destroyed_count;
    for (int j = 0; j < NUM_BASES; j++) begin
      if (destroy_d[j]) begin
        count_d = count_d + CNT_W'(1);
      end
      if (respawn_d[j]) begin
        count_d = count_d - CNT_W'(1);
      end
    end
`ifdef BULLET_COLLISION_RESPAWN_EN
    all_d = (count_d == CNT_W'(NUM_BASES));
`else
    all_d = all_destroyed | (count_d == CNT_W'(NUM_BASES));
`endif
  end

  // State and output registers. On reset, every base is re-armed at once and
  // any respawn timers that were running are discarded.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int j = 0; j < NUM_BASES; j++) begin
        state_q[j] <= ALIVE;
        dmg_q[j]   <= 4'd0;
`ifdef BULLET_COLLISION_RESPAWN_EN
        respawn_cnt_q[j] <= 10'd0;
`endif
      end
      base_hit        <= '0;
      bullet_consumed <= '0;
      enemy_hit       <= 1'b0;
      base_destroyed  <= '0;
      destroyed_count <= '0;
      all_destroyed   <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_BASES; j++) begin
        state_q[j] <= state_d[j];
        dmg_q[j]   <= dmg_d[j];
`ifdef BULLET_COLLISION_RESPAWN_EN
        respawn_cnt_q[j] <= respawn_cnt_d[j];
`endif
      end
      base_hit        <= damage;
      bullet_consumed <= consume_d;
      enemy_hit       <= |damage;
      base_destroyed  <= destroy_d;
      destroyed_count <= count_d;
      all_destroyed   <= all_d;
    end
  end

  // The alive level is a direct decode of the registered base state.
  always_comb begin
    for (int j = 0; j < NUM_BASES; j++) begin
      base_alive[j] = (state_q[j] == ALIVE);
    end
  end

endmodule

// File: tb/tb_bullet_base_collision_array.sv
// -----------------------------------------------------------------------------
// tb_bullet_base_collision_array
//
// Purpose:
//   Self-checking bench for bullet_base_collision_array. A frame-level
//   reference model works out hits, consumes, damage and destruction from the
//   geometric rules, using plain integer distances. The bench then compares
//   the DUT outputs against that model after every frame.
// -----------------------------------------------------------------------------
module tb_bullet_base_collision_array;

  localparam int NBU = 2;
  localparam int NBA = 4;
  localparam int R   = 5;
  localparam int HX  = 32;
  localparam int HY  = 36;
  localparam int H   = 3;
  localparam int RF  = 4;

  logic        frame_clk;
  logic        Reset_n;
  logic [1:0]  bullet_valid;
  logic [19:0] bullet_x;
  logic [19:0] bullet_y;
  logic [39:0] base_tl_x;
  logic [39:0] base_tl_y;
  logic [3:0]  base_hit;
  logic [1:0]  bullet_consumed;
  logic        enemy_hit;
  logic [3:0]  base_destroyed;
  logic [3:0]  base_alive;
  logic [2:0]  destroyed_count;
  logic        all_destroyed;

  logic [18:0] obs;
  logic [18:0] exp_vec;

  int checks = 0;
  int errors = 0;

  bit m_alive   [NBA];
  int m_hits    [NBA];
  int m_resp_at [NBA];
  int frame_no;
  bit m_all;

  bullet_base_collision_array #(
    .NUM_BULLETS(NBU), .NUM_BASES(NBA), .HIT_RADIUS(R),
    .BASE_HALF_X(HX), .BASE_HALF_Y(HY),
    .HITS_TO_DESTROY(H), .RESPAWN_FRAMES(RF)
  ) dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n),
    .bullet_valid(bullet_valid), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .base_tl_x(base_tl_x), .base_tl_y(base_tl_y),
    .base_hit(base_hit), .bullet_consumed(bullet_consumed),
    .enemy_hit(enemy_hit), .base_destroyed(base_destroyed),
    .base_alive(base_alive), .destroyed_count(destroyed_count),
    .all_destroyed(all_destroyed)
  );

  assign obs = {base_hit, bullet_consumed, enemy_hit, base_destroyed,
                base_alive, destroyed_count, all_destroyed};

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Put the model back into its reset state.
  task automatic model_reset();
    for (int j = 0; j < NBA; j++) begin
      m_alive[j]   = 1'b1;
      m_hits[j]    = 0;
      m_resp_at[j] = 0;
    end
    m_all   = 1'b0;
    exp_vec = {4'b0, 2'b0, 1'b0, 4'b0, 4'b1111, 3'd0, 1'b0};
  endtask

  // Apply one frame edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic [3:0] hit;
    logic [1:0] cons;
    logic [3:0] dest;
    logic [3:0] al;
    int dx, dy, cnt;
    bit done;
    hit = '0; cons = '0; dest = '0;
    for (int i = 0; i < NBU; i++) begin
      done = 1'b0;
      if (bullet_valid[i]) begin
        for (int j = 0; j < NBA; j++) begin
          dx = int'(bullet_x[10*i +: 10]) - (int'(base_tl_x[10*j +: 10]) + HX);
          dy = int'(bullet_y[10*i +: 10]) - (int'(base_tl_y[10*j +: 10]) + HY);
          if (dx < 0) dx = -dx;
          if (dy < 0) dy = -dy;
          if (m_alive[j] && !done && dx <= R && dy <= R) begin
            cons[i] = 1'b1;
            hit[j]  = 1'b1;
            done    = 1'b1;
          end
        end
      end
    end
    for (int j = 0; j < NBA; j++) begin
      if (m_alive[j]) begin
        if (hit[j]) begin
          m_hits[j]++;
          if (m_hits[j] == H) begin
            m_alive[j]   = 1'b0;
            m_hits[j]    = 0;
            dest[j]      = 1'b1;
            m_resp_at[j] = frame_no + RF;
          end
        end
      end else begin
`ifdef BULLET_COLLISION_RESPAWN_EN
        if (frame_no == m_resp_at[j]) m_alive[j] = 1'b1;
`endif
      end
    end
    frame_no++;
    cnt = 0;
    for (int j = 0; j < NBA; j++) begin
      al[j] = m_alive[j];
      if (!m_alive[j]) cnt++;
    end
`ifdef BULLET_COLLISION_RESPAWN_EN
    m_all = (cnt == NBA);
`else
    m_all = m_all || (cnt == NBA);
`endif
    exp_vec = {hit, cons, |hit, dest, al, 3'(cnt), m_all};
  endtask

  // Advance one frame: update the model, take the edge, and then let the
  // outputs settle away from the edge.
  task automatic frame();
    model_edge();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic set_bullet(input int i, input bit v, input int x, input int y);
    bullet_valid[i]      = v;
    bullet_x[10*i +: 10] = 10'(x);
    bullet_y[10*i +: 10] = 10'(y);
  endtask

  task automatic set_base(input int j, input int x, input int y);
    base_tl_x[10*j +: 10] = 10'(x);
    base_tl_y[10*j +: 10] = 10'(y);
  endtask

  task automatic default_layout();
    for (int j = 0; j < NBA; j++) set_base(j, 100 + 200 * j, 100);
    set_bullet(0, 1'b0, 0, 0);
    set_bullet(1, 1'b0, 0, 0);
  endtask

  // Short reset pulse that sits entirely between two edges.
  task automatic do_reset();
    Reset_n = 1'b0;
    model_reset();
    #2;
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    default_layout();
    #3;
    checks++;
    if (obs !== exp_vec) begin
      errors++;
      $display("[TB] FAIL reset_values got %h expected %h", obs, exp_vec);
    end
    Reset_n = 1'b1;
    frame();
    checks++;
    if (obs !== exp_vec) begin
      errors++;
      $display("[TB] FAIL reset_idle_frame got %h expected %h", obs, exp_vec);
    end
  endtask

  task automatic test_single_hit();
    do_reset();
    default_layout();
    set_bullet(0, 1'b1, 137, 131);
    frame();
    checks++;
    if (obs !== exp_vec || base_hit !== 4'b0001 || bullet_consumed !== 2'b01 || enemy_hit !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_hit got %h expected %h", obs, exp_vec);
    end
    set_bullet(0, 1'b0, 137, 131);
    frame();
    checks++;
    if (obs !== exp_vec || enemy_hit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_hit_pulse_end got %h expected %h", obs, exp_vec);
    end
  endtask

  task automatic test_window_edge();
    set_bullet(0, 1'b1, 138, 136);
    frame();
    checks++;
    if (obs !== exp_vec || base_hit !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL window_outside got %h expected %h", obs, exp_vec);
    end
    set_bullet(0, 1'b1, 127, 141);
    frame();
    checks++;
    if (obs !== exp_vec || base_hit !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL window_inclusive got %h expected %h", obs, exp_vec);
    end
  endtask

  task automatic test_multi_bullet();
    do_reset();
    default_layout();
    // Two bullets on base1 for two frames, then one bullet: the base is
    // destroyed only on the third damaging frame.
    for (int k = 0; k < 3; k++) begin
      set_bullet(0, 1'b1, 332, 136);
      set_bullet(1, (k < 2), 329, 139);
      frame();
      checks++;
      if (obs !== exp_vec || base_hit !== 4'b0010 || base_destroyed !== ((k == 2) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("[TB] FAIL multi_bullet_frame%0d got %h expected %h", k, obs, exp_vec);
      end
    end
    set_base(2, 100, 100);
    set_bullet(0, 1'b1, 132, 136);
    set_bullet(1, 1'b0, 0, 0);
    frame();
    checks++;
    if (obs !== exp_vec || base_hit !== 4'b0001 || bullet_consumed !== 2'b01) begin
      errors++;
      $display("[TB] FAIL shared_overlap got %h expected %h", obs, exp_vec);
    end
  endtask

  task automatic test_destroy_respawn();
    int last;
    do_reset();
    default_layout();
    set_bullet(0, 1'b1, 732, 136);
    for (int k = 0; k < 3; k++) frame();
    checks++;
    if (obs !== exp_vec || base_destroyed !== 4'b1000 || base_alive !== 4'b0111 || destroyed_count !== 3'd1) begin
      errors++;
      $display("[TB] FAIL destroy got %h expected %h", obs, exp_vec);
    end
    frame();
    checks++;
    if (obs !== exp_vec || base_hit !== 4'b0000 || bullet_consumed !== 2'b00) begin
      errors++;
      $display("[TB] FAIL dead_ignores_bullet got %h expected %h", obs, exp_vec);
    end
    set_bullet(0, 1'b0, 0, 0);
`ifdef BULLET_COLLISION_RESPAWN_EN
    last = 8;
`else
    last = 1005;
`endif
    for (int k = 2; k <= last; k++) begin
      frame();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("[TB] FAIL respawn_frame%0d got %h expected %h", k, obs, exp_vec);
      end
      if (k == 3 || k == 4) begin
        checks++;
`ifdef BULLET_COLLISION_RESPAWN_EN
        if (base_alive[3] !== (k == 4) || destroyed_count !== ((k == 4) ? 3'd0 : 3'd1)) begin
`else
        if (base_alive[3] !== 1'b0 || destroyed_count !== 3'd1) begin
`endif
          errors++;
          $display("[TB] FAIL respawn_timing k=%0d got alive %b count %0d", k, base_alive, destroyed_count);
        end
      end
    end
  endtask

  task automatic test_near_origin();
    do_reset();
    default_layout();
    set_base(0, 0, 0);
    set_bullet(0, 1'b1, 0, 0);
    frame();
    checks++;
    if (obs !== exp_vec || base_hit !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL near_origin_wrap got %h expected %h", obs, exp_vec);
    end
    set_bullet(0, 1'b1, 27, 31);
    frame();
    checks++;
    if (obs !== exp_vec || base_hit !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL near_origin_edge got %h expected %h", obs, exp_vec);
    end
  endtask

  task automatic test_all_destroyed();
    do_reset();
    default_layout();
    for (int k = 0; k < 6; k++) begin
      set_bullet(0, 1'b1, (k < 3) ? 132 : 532, 136);
      set_bullet(1, 1'b1, (k < 3) ? 332 : 732, 136);
      frame();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("[TB] FAIL all_destroyed_frame%0d got %h expected %h", k, obs, exp_vec);
      end
    end
    checks++;
    if (all_destroyed !== 1'b1 || destroyed_count !== 3'd4) begin
      errors++;
      $display("[TB] FAIL all_destroyed got %b count %0d expected 1 count 4", all_destroyed, destroyed_count);
    end
  endtask

  task automatic test_async_reset();
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== exp_vec || base_alive !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL async_reset got %h expected %h", obs, exp_vec);
    end
    #1;
    Reset_n = 1'b1;
    frame();
    checks++;
    if (obs !== exp_vec || base_hit !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL rearm_after_reset got %h expected %h", obs, exp_vec);
    end
  endtask

  task automatic test_random();
    int k, cxk, cyk;
    do_reset();
    default_layout();
    for (int f = 0; f < 400; f++) begin
      if ($urandom_range(0, 29) == 0) do_reset();
      if (f % 25 == 0) begin
        for (int j = 0; j < NBA; j++) set_base(j, j * 60 + $urandom_range(0, 80), $urandom_range(0, 40));
      end
      for (int i = 0; i < NBU; i++) begin
        k   = $urandom_range(0, NBA - 1);
        cxk = int'(base_tl_x[10*k +: 10]) + HX;
        cyk = int'(base_tl_y[10*k +: 10]) + HY;
        if ($urandom_range(0, 7) == 0)
          set_bullet(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 1023), $urandom_range(0, 1023));
        else
          set_bullet(i, ($urandom_range(0, 3) != 0), cxk + $urandom_range(0, 16) - 8, cyk + $urandom_range(0, 16) - 8);
      end
      frame();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("[TB] FAIL random_frame%0d got %h expected %h", f, obs, exp_vec);
      end
    end
  endtask

  initial begin
    Reset_n  = 1'b0;
    frame_no = 0;
    model_reset();
    test_reset();
    test_single_hit();
    test_window_edge();
    test_multi_bullet();
    test_destroy_respawn();
    test_near_origin();
    test_all_destroyed();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bullet_base_collision_array.md
# bullet_base_collision_array

Parametrised collision and damage tracker between the player's bullets and the enemy bases. Every frame it compares all bullet positions against all live base hit-windows in parallel, and issues per-base hit pulses and per-bullet consume pulses. It keeps per-base damage counters and alive/destroyed state, and optionally schedules respawns. It sits between the bullet controller, the base placement logic and the score/display logic, all clocked on `frame_clk`.

## Interface
Parameters:
- `NUM_BULLETS`, default 2: number of player bullet channels.
- `NUM_BASES`, default 4: number of enemy bases tracked.
- `HIT_RADIUS`, default 5: half-width of the square hit window around the base centre, in pixels.
- `BASE_HALF_X`, default 32: x offset from the base top-left corner to its centre.
- `BASE_HALF_Y`, default 36: y offset from the base top-left corner to its centre.
- `HITS_TO_DESTROY`, default 3: number of damaging frames that destroy a base; range 1..15.
- `RESPAWN_FRAMES`, default 120: frames a base stays destroyed; range 1..1023.

Ports:
- `frame_clk`, input, 1: single clock; one rising edge per video frame.
- `Reset_n`, input, 1: asynchronous, active-low reset.
- `bullet_valid`, input, NUM_BULLETS: bullet i is in flight.
- `bullet_x`, `bullet_y`, input, 10×NUM_BULLETS: packed bullet positions; bullet i occupies bits [10i+9:10i].
- `base_tl_x`, `base_tl_y`, input, 10×NUM_BASES: packed base top-left corners, packed the same way.
- `base_hit`, output, NUM_BASES: one-frame pulse when base j took damage.
- `bullet_consumed`, output, NUM_BULLETS: one-frame pulse; the bullet controller must retire bullet i.
- `enemy_hit`, output, 1: OR of `base_hit`, registered in the same cycle as `base_hit`.
- `base_destroyed`, output, NUM_BASES: one-frame pulse when base j transitions to DEAD.
- `base_alive`, output, NUM_BASES: level; base j is in ALIVE.
- `destroyed_count`, output, $clog2(NUM_BASES+1): number of bases currently DEAD.
- `all_destroyed`, output, 1: level; every base is DEAD.

## Operation
- Base centre: cx = tl_x + BASE_HALF_X and cy = tl_y + BASE_HALF_Y, computed at 11 bits with no wrap.
- Overlap(i,j) is true when all of the following hold:
  - `bullet_valid[i]` is 1;
  - base j is ALIVE;
  - bx + R >= cx and bx <= cx + R, and by + R >= cy and by <= cy + R, all compared at 11 bits.
  - This form avoids unsigned underflow near the screen edge.
- The window bounds are inclusive: a distance of exactly R counts as a hit.
- Bullet-to-base assignment:
  - A bullet overlapping several bases is credited only to the lowest-index overlapping base.
  - Every bullet with at least one overlap is consumed.
- Damage per base:
  - A base takes at most one damage per frame, however many bullets are credited to it.
  - Its 4-bit `dmg` counter increments by 1 on each damaging frame.
- Per-base FSM:
  - ALIVE: on a damaging frame where dmg+1 == HITS_TO_DESTROY, go to DEAD, clear `dmg`, pulse `base_destroyed`, and load `respawn_cnt` with RESPAWN_FRAMES-1.
  - DEAD: ignores all bullets. `respawn_cnt` decrements each frame. When it reaches 0, the base returns to ALIVE with dmg = 0 (see Configuration).
- A bullet that is still valid and still overlapping on the next frame damages the base again. Retiring bullets via `bullet_consumed` is the bullet controller's job.
- `destroyed_count` is a registered up/down counter. It is consistent with `base_alive` in the same cycle. Simultaneous destroy and respawn on different bases net correctly.

## Timing
- All outputs are registered. Comparisons use the inputs sampled at edge N; `base_hit`, `bullet_consumed`, `enemy_hit` and `base_destroyed` are high for exactly the cycle following edge N.
- Latency from position to pulse is 1 frame_clk cycle.
- Values while `Reset_n` is low:
  - All pulse outputs are 0.
  - `base_alive` is all 1s.
  - `destroyed_count` is 0 and `all_destroyed` is 0.
  - All `dmg` and `respawn_cnt` are 0.
- Deasserting reset mid-game re-arms every base immediately. In-flight respawn timers are discarded.
- Changing a base's position while DEAD has no effect until it respawns. The window always uses the current inputs.

## Configuration
- `BULLET_COLLISION_RESPAWN_EN` defined:
  - DEAD bases return to ALIVE after RESPAWN_FRAMES frames.
  - The final DEAD frame is the one on which `respawn_cnt` is 0.
  - The base is ALIVE, and hittable again, on the next edge.
- `BULLET_COLLISION_RESPAWN_EN` undefined:
  - DEAD is terminal until reset.
  - The `respawn_cnt` registers are not built.
  - `all_destroyed` latches once every base is dead.

## Test plan
- Single hit:
  - Stimulus: base0 tl=(100,100) (centre 132,136), bullet0 valid at (137,131).
  - Required: `base_hit`=0001, `bullet_consumed`=01 and `enemy_hit`=1 for one cycle; base0 dmg=1.
- Window edge:
  - Stimulus: bullet at (138,136), then at (127,141).
  - Required: the first gives no hit; the second hits (inclusive bound).
- Multiple bullets, one base, and shared overlap:
  - Stimulus: two bullets on base1 in the same frame.
  - Required: `bullet_consumed`=11, base1 dmg +1 only.
  - Stimulus: bases 0 and 2 placed with identical centres.
  - Required: only base0 is credited.
- Destroy:
  - Stimulus: three damaging frames on base3 with HITS_TO_DESTROY=3.
  - Required: `base_destroyed`[3] pulses on the third frame; `base_alive`[3]=0; `destroyed_count`=1; a fourth bullet produces no hit and no consume.
- Respawn, macro defined with RESPAWN_FRAMES=4:
  - Required: base3 is ALIVE again exactly 4 frames after the destroy pulse; `destroyed_count` returns to 0.
  - Without the macro: it stays DEAD for over 1000 frames.
- Near-origin and reset:
  - Stimulus: base tl=(0,0), bullet at (0,0).
  - Required: no hit from underflow wrap.
  - Stimulus: destroy all four bases.
  - Required: `all_destroyed`=1.
  - Stimulus: assert `Reset_n` asynchronously mid-frame.
  - Required: all outputs return to their reset values immediately.
